// File: rtl/toeplitz_row_accum.sv
// GF(2) Toeplitz/circulant matrix-vector accumulator.
// The matrix rows are generated internally from a seed. In circulant mode the row
// rotates left. In Toeplitz mode the row shifts left and takes in fill bits.
// For every set input bit, processed MSB first, the current row is XORed into the
// accumulator. After NUM_WORDS words the accumulator is copied to the result, and
// result_valid pulses for one cycle.
module toeplitz_row_accum #(
  parameter int ROW_W     = 3072,
  parameter int COEFF_W   = 32,
  parameter int NUM_WORDS = 128
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start,
  input  logic               circ,
  input  logic [ROW_W-1:0]   seed,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  input  logic [COEFF_W-1:0] coeff,
  input  logic [COEFF_W-1:0] fill,
  output logic [ROW_W-1:0]   result,
  output logic               result_valid,
  output logic               busy
);

  // Handshake: a word (coeff plus fill) transfers on a rising edge where coeff_valid
  // and coeff_ready are both high. coeff_ready is decoded from state alone, so it
  // never depends on coeff_valid. A held coeff_valid with no coeff_ready leaves the
  // word pending.

  localparam int BC_W = (COEFF_W > 1) ? $clog2(COEFF_W) : 1;
  localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(COEFF_W - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PROC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // The state register is visible hierarchically as "state" for checkers.
  state_t state;
  state_t state_nx;

  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   acc;
  logic               mode;
  logic [COEFF_W-1:0] cw;
  logic [COEFF_W-1:0] fw;
  logic [BC_W-1:0]    bit_cnt;
  logic [WC_W-1:0]    word_cnt;
  logic               row_in;

  // Bit that enters the row LSB: the wrapped MSB (circulant) or the next fill bit.
  assign row_in = mode ? row[ROW_W-1] : fw[COEFF_W-1];

  assign coeff_ready = (state == S_WAIT);
  assign busy        = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_WAIT;
      S_WAIT: if (coeff_valid) state_nx = S_PROC;
      S_PROC: begin
        if (bit_cnt == BIT_LAST) begin
          state_nx = (word_cnt == WORD_LAST) ? S_OUT : S_WAIT;
        end
      end
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: row generation, accumulation, counters and the result register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      row          <= '0;
      acc          <= '0;
      mode         <= 1'b0;
      cw           <= '0;
      fw           <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            row      <= seed;
            acc      <= '0;
            mode     <= circ;
            word_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (coeff_valid) begin
            cw      <= coeff;
            fw      <= fill;
            bit_cnt <= '0;
          end
        end
        S_PROC: begin
          // The accumulate uses the row as it is before this cycle's shift.
          if (cw[COEFF_W-1]) acc <= acc ^ row;
          row <= {row[ROW_W-2:0], row_in};
          cw  <= cw << 1;
          fw  <= fw << 1;
          // The counters stop at their last value instead of wrapping.
          if (bit_cnt == BIT_LAST) begin
            if (word_cnt != WORD_LAST) word_cnt <= word_cnt + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_OUT: begin
          result       <= acc;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/toeplitz_row_accum.md
Name: toeplitz_row_accum

Overview:
- Parametrised GF(2) Toeplitz/circulant matrix-vector accumulator for the hashing datapath.
- Generates its own shifted matrix rows internally from a loaded seed, so no external shift_row is needed.
- Consumes NUM_WORDS input words of COEFF_W bits each through a valid/ready handshake.
- XOR-accumulates the current row into a ROW_W-bit result for every set input bit, then presents the result with a one-cycle valid pulse.

Parameters:
ROW_W, 3072, width of matrix row, accumulator and result
COEFF_W, 32, bits per input word (processed MSB first)
NUM_WORDS, 128, input words per hash (total input bits = NUM_WORDS*COEFF_W)

Ports:
clk_in  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse; begins a hash when IDLE, ignored otherwise
circ  input  1  sampled with start: 1=circulant (rotate row), 0=Toeplitz (shift in fill bits)
seed  input  ROW_W  initial row, sampled with start
coeff_valid  input  1  input word valid
coeff_ready  output  1  block can accept a word (high only in WAIT)
coeff  input  COEFF_W  input data word
fill  input  COEFF_W  Toeplitz fill bits, transferred with coeff (don't-care when circ=1)
result  output  ROW_W  final hash; held until the next start completes
result_valid  output  1  one-cycle pulse when result updates
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at edge): state=IDLE; result=0, result_valid=0, coeff_ready=0, busy=0; row, acc, coeff/fill shift regs and counters cleared.
- Reset mid-operation aborts the hash; result is cleared and no result_valid is produced.
- FSM states: IDLE, WAIT, PROC, OUT.
- IDLE: on start, load row<=seed, acc<=0, mode<=circ, word_cnt<=0; go to WAIT. result is not changed.
- WAIT: coeff_ready=1 (decoded from state).
  - On coeff_valid&coeff_ready: latch cw<=coeff and fw<=fill, bit_cnt<=0, go to PROC.
  - If coeff_valid is low, stay in WAIT indefinitely; no state changes.
- PROC: one bit per cycle, COEFF_W cycles, coeff_ready=0. Each cycle:
  - If cw[MSB], acc <= acc ^ row, using the pre-shift row.
  - If mode=1: row <= {row[ROW_W-2:0], row[ROW_W-1]}.
  - If mode=0: row <= {row[ROW_W-2:0], fw[MSB]}.
  - cw <<= 1, fw <<= 1, bit_cnt++.
  - On the last bit (bit_cnt==COEFF_W-1): word_cnt++. If word_cnt==NUM_WORDS-1, go to OUT; else go to WAIT.
- OUT: result <= acc; result_valid=1 for exactly this one cycle; go to IDLE next edge.
- Throughput: COEFF_W+1 cycles per word minimum. Latency from the final handshake to result_valid = COEFF_W+1 cycles.
- start asserted while busy=1 is ignored, with no effect on the current hash.
- start and coeff_valid asserted together in IDLE: only start acts; the word is accepted in WAIT on the next cycle.
- Counters are sized $clog2 of their limit (minimum 1 bit). Counters never wrap mid-hash.
- Everything is GF(2): XOR only, no carries.

Test Plan (ROW_W=8, COEFF_W=4, NUM_WORDS=2):
- circ=1, seed=8'h01, words 4'hF, 4'hF (valid always high) -> one result_valid pulse, result=8'hFF; 2+2*5 cycles from start to the pulse.
- circ=1, seed=8'h81, words 4'h8, 4'h0 -> result=8'h81.
- circ=0, seed=8'h00, word1 coeff=4'h0 fill=4'hF, word2 coeff=4'h1 fill=4'h0 -> result=8'h78.
- Same as the first case but coeff_valid held low 10 cycles before word2 -> coeff_ready stays 1 throughout, busy=1, result=8'hFF, pulse delayed by 10 cycles.
- rst asserted during PROC of word1 -> next edge: result=0, busy=0, coeff_ready=0, no pulse. A fresh start then completes with the expected value.
- start re-pulsed during PROC -> ignored; result is identical to the uninterrupted run and exactly one result_valid pulse occurs.
